// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package adder_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADD_AB  = 2'd1,
    ADD_CIN = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Requester-side handshake and operand/result bus of the adder sequencer.
interface adder_seq_ctrl_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (output start, op_a, op_b, input busy, done, result, carry_out);
  modport slave  (input start, op_a, op_b, output busy, done, result, carry_out);
endinterface

// File: rtl/adder_4bit.sv
// Combinational 4-bit adder without carry-in.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carry
);
  assign {carry, sum} = 5'(a) + 5'(b);
endmodule

// File: rtl/adder_seq_ctrl.sv
// WIDTH-bit adder built from one shared 4-bit adder, two passes per nibble,
// LS nibble first; fixed 2*NIB cycles from accept to DONE.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  adder_seq_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = (clog2(NIB) < 1) ? 1 : clog2(NIB);

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic             cry, c1, cout;
  logic [3:0]       s1;
  logic [WIDTH-1:0] opa, opb, res;
  logic [3:0]       add_a, add_b, add_s;
  logic             add_c, last;

  assign last = (idx == IW'(NIB - 1));

  adder_4bit u_adder_4bit (.a(add_a), .b(add_b), .sum(add_s), .carry(add_c));

  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    case (state)
      IDLE:    if (bus.start) state_nx = ADD_AB;
      ADD_AB: begin
        add_a    = opa[int'(idx)*NIB_W +: NIB_W];
        add_b    = opb[int'(idx)*NIB_W +: NIB_W];
        state_nx = ADD_CIN;
      end
      ADD_CIN: begin
        add_a    = s1;
        add_b    = {3'b000, cry};
        state_nx = last ? DONE : ADD_AB;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // c1 and the second-pass carry are mutually exclusive, so OR merges them exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cry   <= 1'b0;
      c1    <= 1'b0;
      s1    <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.start) begin
          opa  <= bus.op_a;
          opb  <= bus.op_b;
          idx  <= '0;
          cry  <= 1'b0;
          cout <= 1'b0;
        end
        ADD_AB: begin
          s1 <= add_s;
          c1 <= add_c;
        end
        ADD_CIN: begin
          res[int'(idx)*NIB_W +: NIB_W] <= add_s;
          cry <= c1 | add_c;
          if (last) cout <= c1 | add_c;
          else      idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result    = res;
  assign bus.carry_out = cout;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed and random checks of adder_seq_ctrl at WIDTH=16 and WIDTH=4.
module tb_adder_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl_if #(.WIDTH(16)) b16 ();
  adder_seq_ctrl_if #(.WIDTH(4))  b4 ();

  adder_seq_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  adder_seq_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle16();
    int n = 0;
    @(negedge clk);
    while (b16.busy && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) check("idle16_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle4();
    int n = 0;
    @(negedge clk);
    while (b4.busy && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) check("idle4_timeout", 32'd1, 32'd0);
  endtask

  // Accept an op on the 16-bit DUT and check latency, busy span and result
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ec);
    int lat = -1;
    int bcnt = 0;
    wait_idle16();
    b16.start = 1'b1; b16.op_a = a; b16.op_b = b;
    @(posedge clk); #1;
    b16.start = 1'b0; b16.op_a = 16'($urandom); b16.op_b = 16'($urandom);
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (b16.busy) bcnt++;
      if (b16.done) lat = k;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
    check({tag, "_result"}, 32'(b16.result), 32'(er));
    check({tag, "_carry"}, 32'(b16.carry_out), 32'(ec));
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input bit chk_lat);
    int lat = -1;
    wait_idle4();
    b4.start = 1'b1; b4.op_a = a; b4.op_b = b;
    @(posedge clk); #1;
    b4.start = 1'b0; b4.op_a = 4'($urandom); b4.op_b = 4'($urandom);
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (b4.done) lat = k;
    end
    if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'd2);
    else if (lat < 0) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_sum"}, 32'({b4.carry_out, b4.result}), 32'(5'(a) + 5'(b)));
  endtask

  initial begin
    int          ndone;
    logic [15:0] cap;
    b16.start = 1'b0; b16.op_a = '0; b16.op_b = '0;
    b4.start  = 1'b0; b4.op_a  = '0; b4.op_b  = '0;

    #12;
    check("rst_busy", 32'(b16.busy), 32'd0);
    check("rst_done", 32'(b16.done), 32'd0);
    check("rst_result", 32'(b16.result), 32'd0);
    check("rst_carry", 32'(b16.carry_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // basic op, then result/carry must hold in IDLE
    run16("t1", 16'h1234, 16'h4321, 16'h5555, 1'b0);
    @(posedge clk); #1;
    check("t1_busy_after", 32'(b16.busy), 32'd0);
    check("t1_done_after", 32'(b16.done), 32'd0);
    check("t1_hold", 32'(b16.result), 32'h5555);

    run16("t2", 16'h0FFF, 16'h0001, 16'h1000, 1'b0);
    run16("t3a", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    run16("t3b", 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);

    // start while busy and on the DONE cycle must be ignored
    wait_idle16();
    b16.start = 1'b1; b16.op_a = 16'h0001; b16.op_b = 16'h0001;
    @(posedge clk); #1;
    b16.start = 1'b0;
    ndone = 0; cap = '0;
    for (int k = 1; k <= 14; k++) begin
      b16.start = (k == 3 || k == 9);
      b16.op_a = 16'hAAAA; b16.op_b = 16'h5555;
      @(posedge clk); #1;
      if (b16.done) begin ndone++; cap = b16.result; end
    end
    b16.start = 1'b0;
    check("t4_done_count", 32'(ndone), 32'd1);
    check("t4_result", 32'(cap), 32'h0002);
    check("t4_not_queued", 32'(b16.busy), 32'd0);
    run16("t4b", 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);

    // reset mid-operation
    wait_idle16();
    b16.start = 1'b1; b16.op_a = 16'h1234; b16.op_b = 16'h0001;
    @(posedge clk); #1;
    b16.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(b16.busy), 32'd0);
    check("t5_done", 32'(b16.done), 32'd0);
    check("t5_result", 32'(b16.result), 32'd0);
    check("t5_carry", 32'(b16.carry_out), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (b16.done) ndone++;
    end
    check("t5_no_done", 32'(ndone), 32'd0);
    run16("t5b", 16'h8000, 16'h8000, 16'h0000, 1'b1);

    // 4-bit instance: directed corner then random sweep
    run4("t6", 4'hF, 4'hF, 1'b1);
    check("t6_result", 32'(b4.result), 32'hE);
    check("t6_carry", 32'(b4.carry_out), 32'd1);
    for (int i = 0; i < 1000; i++)
      run4("t6_rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
